rx_frame_ctrl: RTL and testbench

Frame-level controller placed directly after the serial receiver. It consumes the receiver's byte stream (data byte plus one-cycle valid strobe and parity flag) and sequences it into length-prefixed, checksummed frames. It holds each complete frame in a 16-byte buffer until a consumer acknowledges it, and reports framing errors. It is the only block that interprets receiver output; downstream logic sees whole frames only.

---
 rtl/rx_frame_pkg.sv | 37 +++
 rtl/rx_frame_ctrl_frame_buffer.sv | 42 ++++
 rtl/rx_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared definitions for the receive frame controller: state encoding,
// error cause codes, default start-of-frame byte and buffer geometry.
package rx_frame_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned BUF_AW  = 4;
   localparam int unsigned BUF_DEP = 16;
   localparam int unsigned LEN_W   = 5;
   localparam int unsigned ERR_W   = 2;

   localparam logic [DATA_W-1:0] SOF_DEFAULT = 8'hA5;

   localparam logic [ERR_W-1:0] ERR_PARITY  = 2'b00;
   localparam logic [ERR_W-1:0] ERR_LENGTH  = 2'b01;
   localparam logic [ERR_W-1:0] ERR_CHKSUM  = 2'b10;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHKSUM,
      ST_HOLD
   } state_t;

   // One byte as delivered by the serial receiver.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              perr;
   } rx_byte_t;

   // States in which a frame is being assembled.
   function automatic logic is_busy(input state_t s);
      return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHKSUM);
   endfunction

endpackage

// File: rtl/rx_frame_ctrl_frame_buffer.sv
// frame_buffer: 16x8 payload store, one synchronous write port and a
// registered read port. The read address is registered first and the data
// is registered from it, so an address sampled at one edge yields data
// after the following edge. Storage is not reset.
//   clk, rst        : clock, async active-high reset (read path only)
//   wr_en/addr/data : synchronous write port
//   rd_addr         : read address
//   rd_data         : registered read data
module frame_buffer
   import rx_frame_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [BUF_DEP];
   logic [BUF_AW-1:0] rd_addr_q;

   // Write port; contents survive reset and are never cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Two-stage read: address register then data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q <= '0;
         rd_data   <= '0;
      end else begin
         rd_addr_q <= rd_addr;
         rd_data   <= mem[rd_addr_q];
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: turns the receiver byte stream into length-prefixed,
// checksummed frames (SOF, LEN, payload, CHK) held in a 16-byte buffer
// until acknowledged.
//   clk, rst   : clock, async active-high reset
//   rx_data/rx_valid/rx_perr : receiver byte, strobe and parity flag
//   frm_ack    : consumer releases the held frame
//   rd_addr    : payload read address; rd_data registered payload byte
//   frm_ready  : frame held (level); frm_len its payload length
//   err_pulse/err_code : one-cycle error strobe and cause
//   busy       : frame assembly in progress
//   drop_cnt   : bytes dropped while holding, saturating
module rx_frame_ctrl
   import rx_frame_pkg::*;
#(
   parameter int unsigned       MAX_LEN = 16,
   parameter int unsigned       TIMEOUT = 1023,
   parameter logic [DATA_W-1:0] SOF     = SOF_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_perr,
   input  logic              frm_ack,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frm_ready,
   output logic [LEN_W-1:0]  frm_len,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_code,
   output logic              busy,
   output logic [DATA_W-1:0] drop_cnt
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   rx_byte_t rx;
   assign rx = '{data: rx_data, perr: rx_perr};

   state_t              state_q,   state_nxt;
   logic [LEN_W-1:0]    len_q,     len_nxt;
   logic [DATA_W-1:0]   sum_q,     sum_nxt;
   logic [BUF_AW-1:0]   ptr_q,     ptr_nxt;
   logic [TMO_W-1:0]    tmo_q,     tmo_nxt;
   logic [DATA_W-1:0]   drop_nxt;
   logic                err_pulse_nxt;
   logic [ERR_W-1:0]    err_code_nxt;
   logic                wr_en_c;

   frame_buffer u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_c),
      .wr_addr (ptr_q),
      .wr_data (rx.data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt     = state_q;
      len_nxt       = len_q;
      sum_nxt       = sum_q;
      ptr_nxt       = ptr_q;
      tmo_nxt       = tmo_q;
      drop_nxt      = drop_cnt;
      err_pulse_nxt = 1'b0;
      err_code_nxt  = err_code;
      wr_en_c       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && !rx.perr && (rx.data == SOF)) begin
               state_nxt = ST_LEN;
               tmo_nxt   = '0;
            end
         end

         ST_LEN, ST_PAYLOAD, ST_CHKSUM: begin
            if (rx_valid) begin
               // A byte always beats a timeout landing in the same cycle.
               tmo_nxt = '0;
               if (rx.perr) begin
                  err_pulse_nxt = 1'b1;
                  err_code_nxt  = ERR_PARITY;
                  state_nxt     = ST_IDLE;
               end else if (state_q == ST_LEN) begin
                  if ((rx.data == '0) || (rx.data > DATA_W'(MAX_LEN))) begin
                     err_pulse_nxt = 1'b1;
                     err_code_nxt  = ERR_LENGTH;
                     state_nxt     = ST_IDLE;
                  end else begin
                     len_nxt   = LEN_W'(rx.data);
                     sum_nxt   = rx.data;
                     ptr_nxt   = '0;
                     state_nxt = ST_PAYLOAD;
                  end
               end else if (state_q == ST_PAYLOAD) begin
                  wr_en_c = 1'b1;
                  sum_nxt = sum_q + rx.data;
                  if (LEN_W'(ptr_q) == (len_q - LEN_W'(1))) begin
                     state_nxt = ST_CHKSUM;
                  end else begin
                     ptr_nxt = ptr_q + BUF_AW'(1);
                  end
               end else begin
                  if (rx.data == sum_q) begin
                     state_nxt = ST_HOLD;
                  end else begin
                     err_pulse_nxt = 1'b1;
                     err_code_nxt  = ERR_CHKSUM;
                     state_nxt     = ST_IDLE;
                  end
               end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               err_pulse_nxt = 1'b1;
               err_code_nxt  = ERR_TIMEOUT;
               state_nxt     = ST_IDLE;
               tmo_nxt       = '0;
            end else begin
               tmo_nxt = tmo_q + TMO_W'(1);
            end
         end

         ST_HOLD: begin
            // A byte arriving with the ack is still counted, never parsed.
            if (rx_valid && (drop_cnt != '1)) begin
               drop_nxt = drop_cnt + DATA_W'(1);
            end
            if (frm_ack) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         sum_q     <= '0;
         ptr_q     <= '0;
         tmo_q     <= '0;
         drop_cnt  <= '0;
         err_pulse <= 1'b0;
         err_code  <= ERR_PARITY;
         frm_ready <= 1'b0;
         frm_len   <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         len_q     <= len_nxt;
         sum_q     <= sum_nxt;
         ptr_q     <= ptr_nxt;
         tmo_q     <= tmo_nxt;
         drop_cnt  <= drop_nxt;
         err_pulse <= err_pulse_nxt;
         err_code  <= err_code_nxt;
         frm_ready <= (state_nxt == ST_HOLD);
         frm_len   <= (state_nxt == ST_HOLD) ? len_nxt : '0;
         busy      <= is_busy(state_nxt);
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl. Expected frame/error events are
// queued as stimulus is driven and consumed when the DUT reports them.
module tb_rx_frame_ctrl;
   import rx_frame_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_perr;
   logic       frm_ack;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       frm_ready;
   logic [4:0] frm_len;
   logic       err_pulse;
   logic [1:0] err_code;
   logic       busy;
   logic [7:0] drop_cnt;

   rx_frame_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_perr   (rx_perr),
      .frm_ack   (frm_ack),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .frm_ready (frm_ready),
      .frm_len   (frm_len),
      .err_pulse (err_pulse),
      .err_code  (err_code),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_frame;
      logic [4:0] val;
   } sb_ev_t;

   typedef logic [7:0] byte_q_t [$];

   sb_ev_t     sb_q [$];
   sb_ev_t     mon_ev;
   logic       ready_d = 1'b0;
   int         errors  = 0;
   int         checks  = 0;
   byte_q_t    seq;
   logic [7:0] p16 [16];
   logic [7:0] sum16;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic p);
      rx_data  = d;
      rx_valid = 1'b1;
      rx_perr  = p;
      tick();
      rx_valid = 1'b0;
      rx_perr  = 1'b0;
   endtask

   task automatic send_seq(input byte_q_t b);
      foreach (b[i]) send_byte(b[i], 1'b0);
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick();
      tick();
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic ack_chk(input string tag);
      frm_ack = 1'b1;
      tick();
      frm_ack = 1'b0;
      check(tag, 32'(frm_ready), 32'd0);
   endtask

   task automatic expect_ev(input logic is_frame, input logic [4:0] val);
      sb_q.push_back('{is_frame: is_frame, val: val});
   endtask

   // Event monitor: every error strobe cycle and every frm_ready rise
   // must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (err_pulse) begin
            if (sb_q.size() == 0) begin
               check("sb_unexp_err", 32'(err_pulse), 32'd0);
            end else begin
               mon_ev = sb_q.pop_front();
               check("sb_kind_err", 32'(mon_ev.is_frame), 32'd0);
               check("sb_err_code", 32'(err_code), 32'(mon_ev.val));
            end
         end
         if (frm_ready && !ready_d) begin
            if (sb_q.size() == 0) begin
               check("sb_unexp_frm", 32'(frm_ready), 32'd0);
            end else begin
               mon_ev = sb_q.pop_front();
               check("sb_kind_frm", 32'(mon_ev.is_frame), 32'd1);
               check("sb_frm_len", 32'(frm_len), 32'(mon_ev.val));
            end
         end
      end
      ready_d = frm_ready;
   end

   initial begin
      rx_data  = '0;
      rx_valid = 1'b0;
      rx_perr  = 1'b0;
      frm_ack  = 1'b0;
      rd_addr  = '0;
      rst      = 1'b1;
      repeat (3) tick();
      check("rst_ready", 32'(frm_ready), 32'd0);
      check("rst_len",   32'(frm_len),   32'd0);
      check("rst_rdata", 32'(rd_data),   32'd0);
      check("rst_err",   32'(err_pulse), 32'd0);
      check("rst_code",  32'(err_code),  32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_drop",  32'(drop_cnt),  32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Good frame, read back, release.
      expect_ev(1'b1, 5'd3);
      seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      check("good_ready", 32'(frm_ready), 32'd1);
      check("good_len",   32'(frm_len),   32'd3);
      check("good_busy",  32'(busy),      32'd0);
      read_chk("good_rd0", 4'd0, 8'h10);
      read_chk("good_rd1", 4'd1, 8'h20);
      read_chk("good_rd2", 4'd2, 8'h30);
      ack_chk("good_ack");

      // Bad checksum, then a good frame is accepted.
      expect_ev(1'b0, 5'(ERR_CHKSUM));
      seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
      send_seq(seq);
      check("chk_ready", 32'(frm_ready), 32'd0);
      check("chk_busy",  32'(busy),      32'd0);
      expect_ev(1'b1, 5'd2);
      seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
      send_seq(seq);
      check("chk2_ready", 32'(frm_ready), 32'd1);
      read_chk("chk2_rd1", 4'd1, 8'h02);
      ack_chk("chk2_ack");

      // Length 0 and 17 rejected; following bytes ignored until SOF.
      expect_ev(1'b0, 5'(ERR_LENGTH));
      seq = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03};
      send_seq(seq);
      check("len0_busy", 32'(busy), 32'd0);
      expect_ev(1'b0, 5'(ERR_LENGTH));
      seq = '{8'hA5, 8'h11, 8'h05, 8'h06};
      send_seq(seq);
      check("len17_busy", 32'(busy), 32'd0);

      // Maximum length frame.
      sum16 = 8'd16;
      for (int i = 0; i < 16; i++) begin
         p16[i] = 8'(i * 7 + 3);
         sum16  = sum16 + p16[i];
      end
      expect_ev(1'b1, 5'd16);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h10, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(p16[i], 1'b0);
      send_byte(sum16, 1'b0);
      check("max_len", 32'(frm_len), 32'd16);
      read_chk("max_rd0",  4'd0,  8'h03);
      read_chk("max_rd15", 4'd15, 8'h6C);
      ack_chk("max_ack");

      // Parity error on first payload byte discards the frame.
      expect_ev(1'b0, 5'(ERR_PARITY));
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b1);
      check("par_busy",  32'(busy),      32'd0);
      check("par_ready", 32'(frm_ready), 32'd0);

      // Short frame leaves stale bytes from the 16-byte frame.
      expect_ev(1'b1, 5'd3);
      seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      read_chk("stale_rd5", 4'd5, 8'h26);
      ack_chk("stale_ack");

      // Timeout after 1023 idle cycles, reported once.
      expect_ev(1'b0, 5'(ERR_TIMEOUT));
      seq = '{8'hA5, 8'h02, 8'hAA};
      send_seq(seq);
      repeat (1022) tick();
      check("tmo_busy_pre", 32'(busy),      32'd1);
      check("tmo_err_pre",  32'(err_pulse), 32'd0);
      tick();
      check("tmo_err",  32'(err_pulse), 32'd1);
      check("tmo_code", 32'(err_code),  32'(ERR_TIMEOUT));
      check("tmo_busy", 32'(busy),      32'd0);
      repeat (5) tick();

      // Byte on the 1023rd idle cycle prevents the timeout.
      send_seq(seq);
      repeat (1022) tick();
      expect_ev(1'b1, 5'd2);
      send_byte(8'hBB, 1'b0);
      check("tmo_byte_busy", 32'(busy), 32'd1);
      send_byte(8'h67, 1'b0);
      check("tmo_byte_ready", 32'(frm_ready), 32'd1);
      ack_chk("tmo_byte_ack");

      // Byte together with ack in HOLD: counted, not treated as SOF.
      expect_ev(1'b1, 5'd3);
      seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      frm_ack  = 1'b1;
      tick();
      rx_valid = 1'b0;
      frm_ack  = 1'b0;
      check("ackbyte_drop",  32'(drop_cnt),  32'd1);
      check("ackbyte_ready", 32'(frm_ready), 32'd0);
      seq = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      check("ackbyte_busy", 32'(busy), 32'd0);

      // 300 dropped bytes saturate the counter, buffer untouched.
      expect_ev(1'b1, 5'd3);
      seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1'($urandom));
      check("hold_drop",  32'(drop_cnt),  32'd255);
      check("hold_ready", 32'(frm_ready), 32'd1);
      check("hold_len",   32'(frm_len),   32'd3);
      read_chk("hold_rd0", 4'd0, 8'h10);
      read_chk("hold_rd1", 4'd1, 8'h20);
      read_chk("hold_rd2", 4'd2, 8'h30);
      ack_chk("hold_ack");

      // Reset mid-frame: outputs clear at once, no error reported.
      seq = '{8'hA5, 8'h05, 8'h01};
      send_seq(seq);
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_drop",  32'(drop_cnt),  32'd0);
      check("mid_rst_rdata", 32'(rd_data),   32'd0);
      check("mid_rst_ready", 32'(frm_ready), 32'd0);
      check("mid_rst_err",   32'(err_pulse), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();

      // Normal operation after reset.
      expect_ev(1'b1, 5'd3);
      seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
      send_seq(seq);
      check("post_ready", 32'(frm_ready), 32'd1);
      ack_chk("post_ack");

      repeat (3) tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
